// File: rtl/sii9136_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module : sii9136_int_ctrl
// Desc   : Avalon-MM service sequencer for the SiI9136 INT# PIO.
// Rev    : 1.0  initial release
// ============================================================================
module sii9136_int_ctrl #(
    parameter int HOLDOFF_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             irq,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_level,
    output logic [CNT_W-1:0] evt_count,
    output logic             busy
);
    localparam int c_HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLDOFF_CYCLES - 1);
    localparam logic [1:0] c_ADDR_DATA = 2'd0;
    localparam logic [1:0] c_ADDR_MASK = 2'd2;
    localparam logic [1:0] c_ADDR_EDGE = 2'd3;

    typedef enum logic [3:0] {
        S_DISABLED = 4'd0,
        S_EN_CLR   = 4'd1,
        S_EN_MASK  = 4'd2,
        S_IDLE     = 4'd3,
        S_CLEAR    = 4'd4,
        S_RD_ADDR  = 4'd5,
        S_RD_SAMP  = 4'd6,
        S_NOTIFY   = 4'd7,
        S_HOLDOFF  = 4'd8,
        S_DIS_MASK = 4'd9
    } state_t;

    state_t              state_q, state_d;
    logic [c_HOLD_W-1:0] hold_q, hold_d;
    logic                valid_q, valid_d;
    logic                level_q, level_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                w_unused_rd;

    assign w_unused_rd = ^avm_readdata[31:1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_DISABLED;
            hold_q  <= '0;
            valid_q <= 1'b0;
            level_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            level_q <= level_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        valid_d = valid_q;
        level_d = level_q;
        count_d = count_q;
        case (state_q)
            S_DISABLED: if (en) state_d = S_EN_CLR;
            S_EN_CLR:   state_d = S_EN_MASK;
            S_EN_MASK:  state_d = S_IDLE;
            S_IDLE: begin
                if (!en)     state_d = S_DIS_MASK;
                else if (irq) state_d = S_CLEAR;
            end
            // Edge capture is cleared before the level read so a new edge
            // arriving mid-service re-raises irq for a later event.
            S_CLEAR:    state_d = S_RD_ADDR;
            S_RD_ADDR:  state_d = S_RD_SAMP;
            S_RD_SAMP: begin
                level_d = avm_readdata[0];
                valid_d = 1'b1;
                state_d = S_NOTIFY;
            end
            S_NOTIFY: begin
                if (valid_q && evt_ready) begin
                    valid_d = 1'b0;
                    count_d = count_q + CNT_W'(1);
                    hold_d  = c_HOLD_LOAD;
                    state_d = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (hold_q == '0) state_d = en ? S_IDLE : S_DIS_MASK;
                else              hold_d  = hold_q - c_HOLD_W'(1);
            end
            S_DIS_MASK: state_d = S_DISABLED;
            default:    state_d = S_DISABLED;
        endcase
    end

    // Bus strobes decode straight from the state so reset drops them at once.
    always_comb begin
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = c_ADDR_DATA;
        avm_writedata  = 32'd0;
        case (state_q)
            S_EN_CLR, S_CLEAR: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = c_ADDR_EDGE;
            end
            S_EN_MASK: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = c_ADDR_MASK;
                avm_writedata  = 32'd1;
            end
            S_DIS_MASK: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = c_ADDR_MASK;
            end
            S_RD_ADDR: avm_chipselect = 1'b1;
            default: ;
        endcase
    end

    assign evt_valid = valid_q;
    assign evt_level = level_q;
    assign evt_count = count_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_DISABLED);

endmodule
`default_nettype wire
